// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART ALU command protocol: opcodes, frame byte
// order and the requester FSM state encoding.
package uart_alu_pkg;

  localparam int OP_W = 6;

  // ALU opcodes (shared with the responder and the ALU itself)
  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

  // Byte position on the wire: three command bytes out, one result back
  localparam int BYTE_OP  = 0;
  localparam int BYTE_A   = 1;
  localparam int BYTE_B   = 2;
  localparam int BYTE_RES = 3;

  // Requester FSM encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SEND_OP  = 3'd1;
  localparam logic [2:0] ST_WAIT_OP  = 3'd2;
  localparam logic [2:0] ST_SEND_A   = 3'd3;
  localparam logic [2:0] ST_WAIT_A   = 3'd4;
  localparam logic [2:0] ST_SEND_B   = 3'd5;
  localparam logic [2:0] ST_WAIT_B   = 3'd6;
  localparam logic [2:0] ST_WAIT_RSP = 3'd7;

endpackage

// File: rtl/uart_alu_requester_timeout_counter.sv
// Response watchdog: counts enabled cycles from a clear and flags the
// terminal count. Holds at the terminal count, so it never wraps.
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  assign expired = (cnt_q == TERM);

  // Clear dominates; otherwise count while enabled until terminal count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 cnt_q <= '0;
    else if (clear)             cnt_q <= '0;
    else if (enable && !expired) cnt_q <= cnt_q + CW'(1);
  end

endmodule

// File: rtl/uart_alu_requester.sv
// Host-side UART ALU initiator: sends op/A/B through the UART TX, then waits
// on the RX FIFO for one result byte or a timeout.
module uart_alu_requester
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [NB_DATA-3:0] cmd_op,
  input  logic [NB_DATA-1:0] cmd_a,
  input  logic [NB_DATA-1:0] cmd_b,
  output logic               cmd_ready,
  output logic               tx_start,
  output logic [NB_DATA-1:0] tx_data,
  input  logic               tx_done_tick,
  input  logic               rx_empty,
  input  logic [NB_DATA-1:0] rx_data,
  output logic               rx_rd,
  output logic               rsp_valid,
  output logic [NB_DATA-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy
);

  logic [2:0]         state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic [NB_DATA-1:0] rsp_data_q, rsp_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rx_rd_c;
  logic               expired;

  // Watchdog only runs in WAIT_RSP; it is held clear everywhere else so it
  // starts from zero on entry.
  timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != ST_WAIT_RSP),
    .enable (rx_empty),
    .expired(expired)
  );

  // Next-state and datapath loads; a byte arriving on the terminal count
  // takes priority over the timeout.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    tx_data_d   = tx_data_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rx_rd_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_empty) begin
          rx_rd_c = 1'b1;                 // stale byte, discard
        end else if (cmd_valid) begin
          a_d       = cmd_a;
          b_d       = cmd_b;
          tx_data_d = {2'b00, cmd_op};
          state_d   = ST_SEND_OP;
        end
      end
      ST_SEND_OP: state_d = ST_WAIT_OP;
      ST_WAIT_OP: if (tx_done_tick) begin
        tx_data_d = a_q;
        state_d   = ST_SEND_A;
      end
      ST_SEND_A:  state_d = ST_WAIT_A;
      ST_WAIT_A:  if (tx_done_tick) begin
        tx_data_d = b_q;
        state_d   = ST_SEND_B;
      end
      ST_SEND_B:  state_d = ST_WAIT_B;
      ST_WAIT_B:  if (tx_done_tick) state_d = ST_WAIT_RSP;
      ST_WAIT_RSP: begin
        if (!rx_empty) begin
          rx_rd_c     = 1'b1;
          rsp_data_d  = rx_data;
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (expired) begin
          rsp_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      tx_data_q   <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tx_data_q   <= tx_data_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign tx_start  = (state_q == ST_SEND_OP) || (state_q == ST_SEND_A) ||
                     (state_q == ST_SEND_B);
  assign tx_data   = tx_data_q;
  // No FIFO pops while reset is held
  assign rx_rd     = rx_rd_c & reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != ST_IDLE);
  assign cmd_ready = (state_q == ST_IDLE) && rx_empty;

endmodule

// File: tb/tb_uart_alu_requester.sv
// Directed bench for uart_alu_requester: nominal frame, timeout, timeout
// race, stale drain, reset mid-frame and back-to-back commands.
module tb_uart_alu_requester;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [5:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic       cmd_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done_tick;
  logic       rx_empty;
  logic [7:0] rx_data;
  logic       rx_rd;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;

  int errs   = 0;
  int checks = 0;

  uart_alu_requester #(.NB_DATA(8), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_ready   (cmd_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done_tick(tx_done_tick),
    .rx_empty    (rx_empty),
    .rx_data     (rx_data),
    .rx_rd       (rx_rd),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled mid low-phase
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called in a SEND cycle: check the pulse and byte, idle a few WAIT cycles,
  // then deliver tx_done_tick. Returns in the cycle after the done tick.
  task automatic send_byte(input string tag, input logic [7:0] exp);
    #1;
    chk({tag, "_start"}, tx_start, 1);
    chk({tag, "_data"}, tx_data, exp);
    chk({tag, "_busy"}, busy, 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      #1 chk({tag, "_wait_nostart"}, tx_start, 0);
      tick();
    end
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
  endtask

  task automatic frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2);
    send_byte({tag, "_op"}, b0);
    send_byte({tag, "_a"},  b1);
    send_byte({tag, "_b"},  b2);
  endtask

  // Present a command with an empty RX FIFO and let it be accepted
  task automatic issue(input string tag, input logic [5:0] op, input logic [7:0] a,
                       input logic [7:0] b);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    #1 chk({tag, "_ready"}, cmd_ready, 1);
    tick();
    cmd_valid = 1'b0; cmd_op = 6'h3f; cmd_a = 8'hee; cmd_b = 8'hdd;
  endtask

  // Deliver a result byte in the current WAIT_RSP cycle
  task automatic respond(input string tag, input logic [7:0] d);
    rx_empty = 1'b0; rx_data = d;
    #1 chk({tag, "_rd"}, rx_rd, 1);
    tick();
    rx_empty = 1'b1; rx_data = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish exp finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    tx_done_tick = 1'b0; rx_empty = 1'b1; rx_data = '0;

    // Reset state
    tick(); tick();
    #1;
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rx_rd", rx_rd, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    reset = 1'b1;
    tick();

    // Nominal ADD 5+3
    issue("add", 6'b100000, 8'h05, 8'h03);
    frame("add", 8'h20, 8'h05, 8'h03);
    for (int i = 0; i < 3; i++) begin
      #1 chk("add_wait_rd", rx_rd, 0);
      chk("add_wait_busy", busy, 1);
      tick();
    end
    respond("add", 8'h08);
    #1;
    chk("add_rsp_valid", rsp_valid, 1);
    chk("add_rsp_data", rsp_data, 8'h08);
    chk("add_rsp_err", rsp_err, 0);
    chk("add_busy", busy, 0);
    chk("add_rd_after", rx_rd, 0);
    tick();
    #1;
    chk("add_valid_pulse", rsp_valid, 0);
    chk("add_data_hold", rsp_data, 8'h08);

    // Timeout: error exactly 16 cycles after entering WAIT_RSP
    issue("tmo", 6'b100010, 8'h10, 8'h01);
    frame("tmo", 8'h22, 8'h10, 8'h01);
    for (int i = 0; i < 16; i++) begin
      #1 chk("tmo_noerr", rsp_err, 0);
      chk("tmo_nord", rx_rd, 0);
      chk("tmo_busy", busy, 1);
      tick();
    end
    #1;
    chk("tmo_err", rsp_err, 1);
    chk("tmo_noval", rsp_valid, 0);
    chk("tmo_busy_drop", busy, 0);
    tick();
    #1 chk("tmo_err_pulse", rsp_err, 0);

    // Byte arrives on the terminal-count cycle: response wins
    issue("race", 6'b100100, 8'h0f, 8'hf0);
    frame("race", 8'h24, 8'h0f, 8'hf0);
    for (int i = 0; i < 15; i++) tick();
    respond("race", 8'haa);
    #1;
    chk("race_valid", rsp_valid, 1);
    chk("race_data", rsp_data, 8'haa);
    chk("race_noerr", rsp_err, 0);
    tick();
    #1 chk("race_noerr_late", rsp_err, 0);

    // Two stale bytes drained before the command is accepted
    cmd_valid = 1'b1; cmd_op = 6'b100101; cmd_a = 8'h03; cmd_b = 8'h04;
    rx_empty = 1'b0; rx_data = 8'h77;
    for (int i = 0; i < 2; i++) begin
      #1 chk("drain_rd", rx_rd, 1);
      chk("drain_notready", cmd_ready, 0);
      tick();
    end
    rx_empty = 1'b1;
    #1 chk("drain_ready", cmd_ready, 1);
    chk("drain_rd_done", rx_rd, 0);
    tick();
    cmd_valid = 1'b0;
    frame("drain", 8'h25, 8'h03, 8'h04);
    respond("drain", 8'h07);
    #1 chk("drain_rsp", rsp_data, 8'h07);
    tick();

    // Reset while waiting for the A byte to finish
    issue("mid", 6'b100110, 8'hab, 8'hcd);
    send_byte("mid_op", 8'h26);
    #1 chk("mid_a_start", tx_start, 1);
    chk("mid_a_data", tx_data, 8'hab);
    tick();
    reset = 1'b0;
    #1;
    chk("mid_tx_start", tx_start, 0);
    chk("mid_tx_data", tx_data, 0);
    chk("mid_rx_rd", rx_rd, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_rsp_data", rsp_data, 0);
    chk("mid_rsp_err", rsp_err, 0);
    chk("mid_busy", busy, 0);
    tick();
    reset = 1'b1;
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    #1 chk("mid_done_ignored", tx_start, 0);
    chk("mid_idle", busy, 0);
    tick();
    // late result byte is drained, then the new command goes through
    cmd_valid = 1'b1; cmd_op = 6'b100000; cmd_a = 8'h01; cmd_b = 8'h02;
    rx_empty = 1'b0; rx_data = 8'hcc;
    #1 chk("late_rd", rx_rd, 1);
    chk("late_notready", cmd_ready, 0);
    tick();
    rx_empty = 1'b1;
    #1 chk("late_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    frame("late", 8'h20, 8'h01, 8'h02);

    // Back-to-back: new command presented on the rsp_valid cycle
    respond("b2b1", 8'h03);
    cmd_valid = 1'b1; cmd_op = 6'b100111; cmd_a = 8'h9a; cmd_b = 8'hbc;
    #1;
    chk("b2b_valid", rsp_valid, 1);
    chk("b2b_data", rsp_data, 8'h03);
    chk("b2b_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0; cmd_op = 6'h00; cmd_a = 8'h00; cmd_b = 8'h00;
    frame("b2b", 8'h27, 8'h9a, 8'hbc);
    respond("b2b2", 8'h11);
    #1 chk("b2b2_data", rsp_data, 8'h11);
    chk("b2b2_valid", rsp_valid, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
